// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants and fetch state type
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // True when the word is an unconditional jump resolved in fetch.
    function automatic logic is_j_op(input logic [31:0] word);
        return word[31:26] == OP_J;
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// rtl/instr_fetch_sequencer_if.sv - instruction memory port plus fetch-to-decode handshake
interface instr_fetch_sequencer_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - sequential / J-target next-PC computation
module fetch_next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imem_data,
    output logic [31:0] next_pc,
    output logic        is_jump
);

    logic [31:0] pc_plus4;

    // J keeps the upper nibble of the delay-slot address, as MIPS defines it.
    always_comb begin
        pc_plus4 = pc + 32'd4;
        is_jump  = is_j_op(imem_data);
        next_pc  = is_jump ? {pc_plus4[31:28], imem_data[25:0], 2'b00} : pc_plus4;
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - PC sequencer with one-entry fetch register toward decode
module instr_fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                           clk,
    input  logic                           rst,
    instr_fetch_sequencer_if.master        bus,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_target,
    input  logic                           halt_req,
    output logic                           halted,
    output logic                           align_err,
    output logic [31:0]                    fetch_count
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_q;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_q;
    logic        align_err_q;
    logic [31:0] fetch_count_q;

    logic [31:0] next_pc;
    logic        jump_unused;   // reserved for the branch predictor

    logic        handshake;
    logic        ld;
    logic        redir_ok;
    logic        redir_bad;

    fetch_next_pc u_next_pc (
        .pc        (pc_q),
        .imem_data (bus.imem_data),
        .next_pc   (next_pc),
        .is_jump   (jump_unused)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a misaligned redirect or a halt request parks the sequencer.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && (redir_bad || halt_req)) begin
            state_d = HALT;
        end
    end

    // Control decode: redirect outranks loading; nothing is loaded in HALT.
    always_comb begin
        handshake = out_valid_q & bus.out_ready;
        ld        = 1'b0;
        redir_ok  = 1'b0;
        redir_bad = 1'b0;
        halted    = (state_q == HALT);
        if (state_q == RUN) begin
            if (redirect_valid) begin
                if (redirect_target[1:0] != 2'b00) begin
                    redir_bad = 1'b1;
                end else begin
                    redir_ok = 1'b1;
                end
            end else begin
                ld = ~out_valid_q | bus.out_ready;
            end
        end
    end

    // PC and fetch register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_pc_q    <= 32'd0;
            align_err_q <= 1'b0;
        end else if (redir_ok) begin
            pc_q        <= redirect_target;
            out_valid_q <= 1'b0;
        end else if (redir_bad) begin
            out_valid_q <= 1'b0;
            align_err_q <= 1'b1;
        end else if (ld) begin
            out_instr_q <= bus.imem_data;
            out_pc_q    <= pc_q;
            out_valid_q <= 1'b1;
            pc_q        <= next_pc;
        end else if (state_q == HALT && handshake) begin
            out_valid_q <= 1'b0;
        end
    end

    // Completed handshakes, including one that coincides with a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= 32'd0;
        end else if (handshake) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign align_err     = align_err_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - scoreboard bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;

    localparam logic [31:0] I_ADDI1 = 32'h2001_0001;
    localparam logic [31:0] I_ADDI2 = 32'h2002_0002;
    localparam logic [31:0] I_ADD1  = 32'h0022_1820;
    localparam logic [31:0] I_ADD2  = 32'h0063_2020;
    localparam logic [31:0] I_J1    = 32'h0800_0001;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        halted;
    logic        align_err;
    logic [31:0] fetch_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    instr_fetch_sequencer_if bus();

    instr_fetch_sequencer #(.RESET_PC(32'd0)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .halted          (halted),
        .align_err       (align_err),
        .fetch_count     (fetch_count)
    );

    function automatic logic [31:0] prog(input logic [31:0] a);
        case (a)
            32'd0:   return I_ADDI1;
            32'd4:   return I_ADDI2;
            32'd8:   return I_ADD1;
            32'd12:  return I_ADD2;
            32'd16:  return I_J1;
            default: return 32'd0;
        endcase
    endfunction

    always_comb bus.imem_data = prog(bus.imem_addr);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_hs(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = prog(pc);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check32({tag, "_valid"},  {31'd0, bus.out_valid}, 32'd0);
        check32({tag, "_pc"},     bus.out_pc, 32'd0);
        check32({tag, "_instr"},  bus.out_instr, 32'd0);
        check32({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check32({tag, "_alerr"},  {31'd0, align_err}, 32'd0);
        check32({tag, "_count"},  fetch_count, 32'd0);
        check32({tag, "_addr"},   bus.imem_addr, 32'd0);
    endtask

    // Monitor: every completed handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL hs_unexpected: got pc %h required no handshake", bus.out_pc);
            end else begin
                e = sb.pop_front();
                check32("hs_pc", bus.out_pc, e.pc);
                check32("hs_instr", bus.out_instr, e.instr);
            end
        end
    end

    initial begin
        logic [31:0] stream [10];
        stream = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd4, 32'd8, 32'd12, 32'd16, 32'd4};

        rst             = 1'b1;
        bus.out_ready   = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        halt_req        = 1'b0;
        tick();
        tick();
        check_reset("rst0");

        // Straight-line program with a J back to 4, decode always ready.
        for (int i = 0; i < 10; i++) expect_hs(stream[i]);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        repeat (11) tick();
        bus.out_ready = 1'b0;
        check32("stream_count", fetch_count, 32'd10);
        check32("stall_pc0", bus.out_pc, 32'd8);

        // Stall three cycles on the add at 8.
        for (int i = 0; i < 3; i++) begin
            tick();
            check32("stall_pc", bus.out_pc, 32'd8);
            check32("stall_instr", bus.out_instr, I_ADD1);
            check32("stall_addr", bus.imem_addr, 32'd12);
            check32("stall_count", fetch_count, 32'd10);
            check32("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        expect_hs(32'd8);
        bus.out_ready = 1'b1;
        tick();
        check32("release_pc", bus.out_pc, 32'd12);
        check32("release_count", fetch_count, 32'd11);

        // Aligned redirect to 8 with a concurrent handshake of 12.
        expect_hs(32'd12);
        redirect_valid  = 1'b1;
        redirect_target = 32'd8;
        tick();
        redirect_valid  = 1'b0;
        check32("redir_valid", {31'd0, bus.out_valid}, 32'd0);
        check32("redir_count", fetch_count, 32'd12);
        check32("redir_addr", bus.imem_addr, 32'd8);
        tick();
        check32("redir_tgt_valid", {31'd0, bus.out_valid}, 32'd1);
        check32("redir_tgt_pc", bus.out_pc, 32'd8);
        expect_hs(32'd8);
        tick();
        check32("post_redir_pc", bus.out_pc, 32'd12);

        // Misaligned redirect halts with align_err; later redirect ignored.
        expect_hs(32'd12);
        redirect_valid  = 1'b1;
        redirect_target = 32'd6;
        tick();
        redirect_valid  = 1'b0;
        check32("mis_halted", {31'd0, halted}, 32'd1);
        check32("mis_alerr", {31'd0, align_err}, 32'd1);
        check32("mis_valid", {31'd0, bus.out_valid}, 32'd0);
        check32("mis_count", fetch_count, 32'd14);
        check32("mis_addr", bus.imem_addr, 32'd16);
        redirect_valid  = 1'b1;
        redirect_target = 32'd0;
        tick();
        redirect_valid  = 1'b0;
        check32("ign_addr", bus.imem_addr, 32'd16);
        check32("ign_halted", {31'd0, halted}, 32'd1);
        tick();
        check32("ign_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset leaves HALT.
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        check_reset("rst1");
        rst = 1'b0;
        tick();
        check32("first_valid", {31'd0, bus.out_valid}, 32'd1);
        check32("first_pc", bus.out_pc, 32'd0);
        check32("first_instr", bus.out_instr, I_ADDI1);
        check32("first_addr", bus.imem_addr, 32'd4);
        tick();
        check32("stall2_pc", bus.out_pc, 32'd0);

        // Reset mid-stall with a concurrent redirect: reset wins.
        rst             = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'd8;
        tick();
        check_reset("rst2");
        rst            = 1'b0;
        redirect_valid = 1'b0;
        tick();
        check32("rst2_valid", {31'd0, bus.out_valid}, 32'd1);
        check32("rst2_pc", bus.out_pc, 32'd0);
        expect_hs(32'd0);
        bus.out_ready = 1'b1;
        tick();
        check32("pre_halt_pc", bus.out_pc, 32'd4);
        check32("pre_halt_count", fetch_count, 32'd1);

        // halt_req while stalled on 4: instruction stays until consumed.
        bus.out_ready = 1'b0;
        halt_req      = 1'b1;
        tick();
        halt_req = 1'b0;
        check32("hreq_halted", {31'd0, halted}, 32'd1);
        check32("hreq_valid", {31'd0, bus.out_valid}, 32'd1);
        check32("hreq_pc", bus.out_pc, 32'd4);
        check32("hreq_addr", bus.imem_addr, 32'd8);
        tick();
        check32("hreq_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        expect_hs(32'd4);
        bus.out_ready = 1'b1;
        tick();
        check32("hdrain_valid", {31'd0, bus.out_valid}, 32'd0);
        check32("hdrain_count", fetch_count, 32'd2);
        repeat (2) tick();
        check32("hidle_valid", {31'd0, bus.out_valid}, 32'd0);
        check32("hidle_count", fetch_count, 32'd2);
        check32("hidle_addr", bus.imem_addr, 32'd8);
        check32("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Sequences the combinational instruction memory of the MIPS core: holds the program counter, drives the memory address every cycle, and registers the returned word into a one-entry fetch stage toward decode with a valid/ready handshake. Resolves unconditional jumps (J) locally with zero bubbles and accepts taken-branch redirects from execute. Sits between the instruction memory and the decode stage; it is the only driver of the instruction-memory address.

## Interface
- `RESET_PC`, default 32'd0: PC loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  byte address to instruction memory, equal to `pc` at all times.
- `imem_data`  in  32  instruction word returned combinationally for `imem_addr`.
- `out_valid`  out  1  fetch register holds an instruction for decode.
- `out_ready`  in  1  decode accepts the instruction this cycle.
- `out_instr`  out  32  registered instruction word.
- `out_pc`  out  32  address `out_instr` was fetched from.
- `redirect_valid`  in  1  execute reports a taken branch; pulse, one cycle.
- `redirect_target`  in  32  new fetch address.
- `halt_req`  in  1  stop fetching; sticky until `rst`.
- `halted`  out  1  sequencer is in HALT.
- `align_err`  out  1  HALT was entered because of a misaligned target; sticky.
- `fetch_count`  out  32  number of completed `out_valid & out_ready` handshakes, wraps at 2^32.

## Operation
- States: RUN, HALT. Reset enters RUN.
- Reset values: `pc`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0, `halted`=0, `align_err`=0, `fetch_count`=0.
- Load condition `ld` = RUN & (~`out_valid` | `out_ready`). On `ld`: `out_instr`<=`imem_data`, `out_pc`<=`pc`, `out_valid`<=1, `pc`<=next_pc.
- next_pc: if `imem_data[31:26]`==OP_J, it is {(`pc`+4)[31:28], `imem_data[25:0]`, 2'b00}; otherwise `pc`+4 (32-bit wrap). The J word is still delivered to decode, which treats it as a no-op.
- When `out_valid` & ~`out_ready`: hold `pc`, `out_*` unchanged (stall). `imem_addr` stays stable.
- Redirect, highest priority in RUN: `pc`<=`redirect_target`, `out_valid`<=0 (flush), no load that cycle. A concurrent handshake still counts in `fetch_count`.
- Misaligned redirect (`redirect_target[1:0]`!=0): enter HALT, set `align_err`, `out_valid`<=0, `pc` unchanged.
- `halt_req` in RUN, with no redirect: enter HALT next edge. The instruction already in the fetch register stays valid and may still be consumed; no further loads occur. If `redirect_valid` and `halt_req` are asserted together, apply the redirect (update `pc` and flush, or take the misaligned-redirect path) and enter HALT.
- HALT: `halted`=1; redirects ignored; only `rst` leaves.
- `rst` has priority over everything, including mid-stall and mid-redirect.

## Timing
- Address-to-output latency: 1 cycle. First `out_valid`=1 on the first edge after `rst` deasserts, with `out_pc`=RESET_PC.
- Throughput: 1 instruction/cycle while `out_ready`=1. A J costs no bubble.
- Redirect penalty: the edge that takes the redirect clears `out_valid`. The instruction at the target is valid one edge later, so there is 1 empty cycle.
- `halted` rises on the edge after the causing `halt_req` or misaligned redirect.
- `fetch_count` updates on the edge of the handshake.

## Structure
- Shared package `mips_pkg`: opcode constants (OP_R, OP_ADDI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J), funct constants, and the state enum `fetch_state_t` {RUN, HALT}. The instruction memory uses the same constants.
- One combinational sub-module `fetch_next_pc`. Inputs: `pc`, `imem_data`. Outputs: next_pc and `is_jump`. It also serves a later branch predictor.

## Test plan
- Program {addi, addi, add, add, J 26'd1} at 0..16, `out_ready`=1 throughout. Required `out_pc` sequence: 0, 4, 8, 12, 16, 4, 8, 12, 16, 4, … with no gaps. `fetch_count`=10 after 10 valid cycles.
- Hold `out_ready`=0 for 3 cycles while `out_pc`=8. `out_instr`, `out_pc` and `imem_addr` stay stable (`out_pc`=8, `imem_addr`=12). `fetch_count` is unchanged. Releasing `out_ready` gives `out_pc`=12 on the next edge.
- `redirect_valid` with target 32'd8 while `out_pc`=12 and the handshake completes. On the next edge `out_valid`=0; one edge later `out_pc`=8. `fetch_count` counts the 12 handshake.
- Redirect with target 32'd6: `halted`=1 and `align_err`=1 on the next edge, `out_valid`=0. A later redirect to 32'd0 is ignored.
- `halt_req` while `out_pc`=4 and `out_ready`=0: `halted`=1, `out_valid` stays 1 until `out_ready`=1, then drops to 0, with no further loads.
- `rst` asserted during a stall with `out_valid`=1: all outputs return to reset values on the next edge. `out_pc`=0 is valid one edge after `rst` deasserts.
